// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Op codes mirror the E-stage decode; state codes are kept as plain constants.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // Ops that occupy the unit for multiple cycles (mult/multu/div/divu).
  function automatic logic is_arith(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request / HI-LO result bundle between the pipeline and md_unit.
interface md_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, d_md,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, d_md,
    output busy, md_stall, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Purely combinational 32x32 multiply / divide datapath.
// Division works on magnitudes so the 0x80000000 / -1 case needs no special path.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  result,
  output logic        div_by_zero
);

  logic        signed_div;
  logic [63:0] sext_a;
  logic [63:0] sext_b;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] safe_divisor;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    signed_div   = (op == MD_DIV);
    sext_a       = {{32{a[31]}}, a};
    sext_b       = {{32{b[31]}}, b};
    dividend     = (signed_div && a[31]) ? (~a + 32'd1) : a;
    divisor      = (signed_div && b[31]) ? (~b + 32'd1) : b;
    // A zero divisor is replaced so the divider never produces X; the flag discards the result.
    safe_divisor = (divisor == 32'd0) ? 32'd1 : divisor;
    mag_q        = dividend / safe_divisor;
    mag_r        = dividend % safe_divisor;
    quot         = (signed_div && (a[31] ^ b[31])) ? (~mag_q + 32'd1) : mag_q;
    rem          = (signed_div && a[31]) ? (~mag_r + 32'd1) : mag_r;
    div_by_zero  = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    result = '0;
    case (op)
      MD_MULT:  result = sext_a * sext_b;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV,
      MD_DIVU: begin
        result.hi = rem;
        result.lo = quot;
      end
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// The result is computed at issue and held until the busy counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_dbz;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  md_result_t  calc_result;
  logic        calc_dbz;

  md_calc u_calc (
    .op          (bus.op),
    .a           (bus.a),
    .b           (bus.b),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      res_dbz <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_arith(bus.op)) begin
              res_hi  <= calc_result.hi;
              res_lo  <= calc_result.lo;
              res_dbz <= calc_dbz;
              cnt     <= ((bus.op == MD_MULT) || (bus.op == MD_MULTU)) ? MULT_CNT : DIV_CNT;
              state   <= ST_BUSY;
            end else if (bus.op == MD_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == MD_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        default: begin
          // Starts arriving here are dropped; the hazard unit keeps them from issuing.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!res_dbz) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy     = (state == ST_BUSY);
  assign bus.md_stall = bus.d_md & (bus.busy | (bus.start & is_arith(bus.op)));
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized back-to-back ops
// compared against a plain-arithmetic HI/LO model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural effect of one op on {HI,LO}, using native 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op);
    if (op <= 3'd1) return MULT_N;
    if (op <= 3'd3) return DIV_N;
    return 0;
  endfunction

  // Called on a falling edge; holds start for exactly one cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    {exp_hi, exp_lo} = ref_md(op, a, b, {exp_hi, exp_lo});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.a     = '0;
    bus.b     = '0;
    bus.d_md  = 1'b1;
    exp_hi    = '0;
    exp_lo    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.md_stall); end
    bus.d_md = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    applyStimulus(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL mult_busy: got %0d cycles expected 5", n); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", bus.lo); end
    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL multu_busy: got %0d cycles expected 5", n); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL div_busy: got %0d cycles expected 10", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", bus.hi); end
    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", bus.hi); end
  endtask

  task automatic test_div_by_zero();
    int n;
    applyStimulus(MD_MTHI, 32'h11, 32'd0);
    checks++; if (bus.hi !== 32'h11) begin errors++; $display("[TB] FAIL mthi_latency: got %h expected 00000011", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", bus.busy); end
    applyStimulus(MD_MTLO, 32'h22, 32'd0);
    checks++; if (bus.lo !== 32'h22) begin errors++; $display("[TB] FAIL mtlo_latency: got %h expected 00000022", bus.lo); end
    applyStimulus(MD_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL divz_busy: got %0d cycles expected 10", n); end
    checks++; if (bus.hi !== 32'h11) begin errors++; $display("[TB] FAIL divz_hi: got %h expected 00000011", bus.hi); end
    checks++; if (bus.lo !== 32'h22) begin errors++; $display("[TB] FAIL divz_lo: got %h expected 00000022", bus.lo); end
  endtask

  task automatic test_stall();
    int n;
    int stall_cnt;
    bus.d_md  = 1'b1;
    bus.op    = MD_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    {exp_hi, exp_lo} = ref_md(MD_DIV, 32'd100, 32'd9, {exp_hi, exp_lo});
    #1;
    checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_issue: got %b expected 1", bus.md_stall); end
    @(negedge clk);
    bus.start = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < DIV_N; i++) begin
      if (bus.md_stall === 1'b1) stall_cnt++;
      @(negedge clk);
    end
    checks++; if (stall_cnt != DIV_N) begin errors++; $display("[TB] FAIL stall_busy: got %0d cycles expected %0d", stall_cnt, DIV_N); end
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got %b expected 0", bus.md_stall); end
    checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL stall_div_lo: got %h expected %h", bus.lo, exp_lo); end
    bus.op    = MD_MTHI;
    bus.start = 1'b1;
    #1;
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_mthi: got %b expected 0", bus.md_stall); end
    bus.start = 1'b0;
    bus.d_md  = 1'b0;
    bus.op    = MD_MULT;
    bus.start = 1'b1;
    #1;
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_dmd: got %b expected 0", bus.md_stall); end
    bus.start = 1'b0;
    @(negedge clk);
    wait_idle(n);
  endtask

  task automatic test_reset_mid();
    applyStimulus(MD_DIV, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL abort_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL abort_lo: got %h expected 0", bus.lo); end
    repeat (DIV_N + 2) @(negedge clk);
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL abort_no_commit: got %h expected 0", bus.lo); end
    applyStimulus(MD_MTLO, 32'h5, 32'd0);
    checks++; if (bus.lo !== 32'h5) begin errors++; $display("[TB] FAIL abort_mtlo: got %h expected 00000005", bus.lo); end
    applyStimulus(MD_MTHI, 32'hABC, 32'd0);
    bus.op    = MD_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    bus.start = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_prio_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_prio_hi: got %h expected 0", bus.hi); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20)) | ($urandom_range(0, 1) == 1 ? 32'hFFFFFF00 : 32'd0);
      applyStimulus(op, a, b);
      wait_idle(n);
      checks++; if (n != ref_latency(op)) begin errors++; $display("[TB] FAIL rand_busy[%0d] op=%0d: got %0d cycles expected %0d", i, op, n, ref_latency(op)); end
      checks++; if (bus.hi !== exp_hi) begin errors++; $display("[TB] FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.hi, exp_hi); end
      checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.lo, exp_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
